// File: rtl/world_to_pixel_pkg.sv
// Shared types and constants for the world-to-pixel conversion pipeline.
package world_to_pixel_pkg;

    // Internal coordinate width. It is wide enough to hold a sign-extended
    // world delta, shifted left by the largest zoom-in, plus the screen
    // offset, without overflow. The design requires
    // WORLD_BITS - min(SCALE_LEVEL, 0) + 2 <= WIDE_BITS.
    localparam int WIDE_BITS = 96;

    // A point travelling through the pipeline. Stage 1 holds the camera
    // relative delta (dx, dy). Stage 2 holds the screen position (px, py).
    typedef struct packed {
        logic signed [WIDE_BITS-1:0] x;
        logic signed [WIDE_BITS-1:0] y;
    } point_rec_t;

    // Contents of one pipeline stage register: an occupancy flag plus the
    // point record.
    typedef struct packed {
        logic       valid;
        point_rec_t pt;
    } stage_t;

    // Screen centre column. The screen centre maps to the camera position.
    function automatic int half_width(input int pixel_width);
        return pixel_width / 2;
    endfunction

    // Screen centre row.
    function automatic int half_height(input int pixel_height);
        return pixel_height / 2;
    endfunction

endpackage

// File: rtl/world_to_pixel_pipe_stage_reg.sv
// Reusable elastic stage register that carries one point record.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid must not depend on ready. Ready here is combinational from
// the stage's own occupancy and the downstream ready. This lets a full
// stage accept a new point in the same cycle it hands its old point on,
// so the stage adds no bubble.
module pipe_stage_reg
    import world_to_pixel_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       up_valid,
    input  point_rec_t up_pt,
    output logic       up_ready,
    input  logic       dn_ready,
    output stage_t     stage
);

    // The stage can load when it is empty or when its current point leaves now.
    assign up_ready = !stage.valid || dn_ready;

    // Load or drain the stage. The payload is only written for real points.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stage <= '0;
        end else if (up_ready) begin
            stage.valid <= up_valid;
            if (up_valid) begin
                stage.pt <= up_pt;
            end
        end
    end

endmodule

// File: rtl/world_to_pixel.sv
// Converts world coordinates to screen pixels relative to a latched camera.
// Stage 1 subtracts the camera position. Stage 2 applies the zoom and the
// screen-centre offset. Visibility and the pixel outputs are decoded from
// the stage-2 register, so they stay stable while downstream stalls.
module world_to_pixel
    import world_to_pixel_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 1280,
    parameter int PIXEL_HEIGHT = 720,
    parameter int WORLD_BITS   = 32,
    parameter int SCALE_LEVEL  = 0,
    parameter int CNT_BITS     = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic signed [WORLD_BITS-1:0]    camera_x_in,
    input  logic signed [WORLD_BITS-1:0]    camera_y_in,
    input  logic                            cam_update_in,
    input  logic signed [WORLD_BITS-1:0]    world_x_in,
    input  logic signed [WORLD_BITS-1:0]    world_y_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [$clog2(PIXEL_WIDTH)-1:0]  hcount_out,
    output logic [$clog2(PIXEL_HEIGHT)-1:0] vcount_out,
    output logic                            visible_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [CNT_BITS-1:0]             visible_count_out,
    output logic [CNT_BITS-1:0]             culled_count_out
);

    localparam int HW       = $clog2(PIXEL_WIDTH);
    localparam int VW       = $clog2(PIXEL_HEIGHT);
    localparam int EXT_BITS = WIDE_BITS - WORLD_BITS;
    localparam int SHIFT    = (SCALE_LEVEL >= 0) ? SCALE_LEVEL : -SCALE_LEVEL;

    localparam logic signed [WIDE_BITS-1:0] HALF_W = WIDE_BITS'(half_width(PIXEL_WIDTH));
    localparam logic signed [WIDE_BITS-1:0] HALF_H = WIDE_BITS'(half_height(PIXEL_HEIGHT));
    localparam logic signed [WIDE_BITS-1:0] PIX_W  = WIDE_BITS'(PIXEL_WIDTH);
    localparam logic signed [WIDE_BITS-1:0] PIX_H  = WIDE_BITS'(PIXEL_HEIGHT);
    localparam logic [CNT_BITS-1:0]         CNT_ONE = CNT_BITS'(1);

    // Camera shadow registers and the camera value seen by stage 1 this cycle.
    logic signed [WORLD_BITS-1:0] cam_x, cam_y;
    logic signed [WORLD_BITS-1:0] cam_x_eff, cam_y_eff;
    logic signed [WORLD_BITS-1:0] dx, dy;

    // Pipeline records.
    point_rec_t s1_in, s2_in;
    stage_t     s1, s2;
    logic       s2_up_ready;

    // Stage-2 datapath.
    logic signed [WIDE_BITS-1:0] s1_x, s1_y;
    logic signed [WIDE_BITS-1:0] sx, sy;
    logic signed [WIDE_BITS-1:0] px, py;
    logic                        on_screen;
    logic                        out_xfer;

    // Capture the camera on an update pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cam_x <= '0;
            cam_y <= '0;
        end else if (cam_update_in) begin
            cam_x <= camera_x_in;
            cam_y <= camera_y_in;
        end
    end

    // Stage 1 input: camera-relative delta. The delta wraps at WORLD_BITS and is
    // then sign-extended. A point accepted in the update cycle already sees the
    // new camera.
    always_comb begin
        cam_x_eff = cam_update_in ? camera_x_in : cam_x;
        cam_y_eff = cam_update_in ? camera_y_in : cam_y;
        dx        = world_x_in - cam_x_eff;
        dy        = world_y_in - cam_y_eff;
        s1_in.x   = {{EXT_BITS{dx[WORLD_BITS-1]}}, dx};
        s1_in.y   = {{EXT_BITS{dy[WORLD_BITS-1]}}, dy};
    end

    pipe_stage_reg u_stage1 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .up_valid (valid_in),
        .up_pt    (s1_in),
        .up_ready (ready_out),
        .dn_ready (s2_up_ready),
        .stage    (s1)
    );

    assign s1_x = $signed(s1.pt.x);
    assign s1_y = $signed(s1.pt.y);

    // Zoom. Zooming out is an arithmetic right shift, which rounds toward minus
    // infinity. Zooming in is a left shift inside the wide internal format.
    generate
        if (SCALE_LEVEL >= 0) begin : g_zoom_out
            assign sx = s1_x >>> SHIFT;
            assign sy = s1_y >>> SHIFT;
        end else begin : g_zoom_in
            assign sx = s1_x <<< SHIFT;
            assign sy = s1_y <<< SHIFT;
        end
    endgenerate

    // Stage 2 input: move the origin from the screen centre to the top-left corner.
    always_comb begin
        s2_in.x = sx + HALF_W;
        s2_in.y = sy + HALF_H;
    end

    pipe_stage_reg u_stage2 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .up_valid (s1.valid),
        .up_pt    (s2_in),
        .up_ready (s2_up_ready),
        .dn_ready (ready_in),
        .stage    (s2)
    );

    // Output decode. An empty stage reports not-visible with zero coordinates.
    always_comb begin
        px          = $signed(s2.pt.x);
        py          = $signed(s2.pt.y);
        on_screen   = s2.valid
                      && !px[WIDE_BITS-1] && (px < PIX_W)
                      && !py[WIDE_BITS-1] && (py < PIX_H);
        valid_out   = s2.valid;
        visible_out = on_screen;
        hcount_out  = on_screen ? px[HW-1:0] : '0;
        vcount_out  = on_screen ? py[VW-1:0] : '0;
        out_xfer    = s2.valid && ready_in;
    end

    // Statistics. A camera update starts a fresh count window. That window
    // includes the point transferring in the update cycle, if there is one.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            visible_count_out <= '0;
            culled_count_out  <= '0;
        end else if (cam_update_in) begin
            visible_count_out <= (out_xfer && on_screen)  ? CNT_ONE : '0;
            culled_count_out  <= (out_xfer && !on_screen) ? CNT_ONE : '0;
        end else if (out_xfer) begin
            if (on_screen) begin
                if (visible_count_out != '1) begin
                    visible_count_out <= visible_count_out + CNT_ONE;
                end
            end else begin
                if (culled_count_out != '1) begin
                    culled_count_out <= culled_count_out + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_world_to_pixel.sv
// Directed bench for world_to_pixel. Two instances (zoom 0 and zoom 2) share
// clock, reset, camera and handshake inputs. Each instance has its own world inputs.
`timescale 1ns/1ps
module tb_world_to_pixel;

    localparam int W = 22;  // {visible, hcount[10:0], vcount[9:0]}

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic signed [31:0] cam_x, cam_y;
    logic cam_upd;
    logic signed [31:0] wx0, wy0, wx2, wy2;
    logic vin, rin;
    logic rdy0, rdy2, vo0, vo2, vis0, vis2;
    logic [10:0] hc0, hc2;
    logic [9:0]  vc0, vc2;
    logic [15:0] vcnt0, ccnt0, vcnt2, ccnt2;

    int checks = 0;
    int failures = 0;

    logic signed [31:0] src_x0[$], src_y0[$], src_x2[$], src_y2[$];
    logic [W-1:0] exp0_q[$], exp2_q[$], obs0_q[$], obs2_q[$];
    int obs_cyc[$];
    int stall_viol;
    logic [15:0] upd_vcnt0, upd_ccnt0, upd_vcnt2, upd_ccnt2;

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    world_to_pixel #(.PIXEL_WIDTH(1280), .PIXEL_HEIGHT(720), .WORLD_BITS(32),
                     .SCALE_LEVEL(0), .CNT_BITS(16)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .camera_x_in(cam_x), .camera_y_in(cam_y), .cam_update_in(cam_upd),
        .world_x_in(wx0), .world_y_in(wy0), .valid_in(vin), .ready_out(rdy0),
        .hcount_out(hc0), .vcount_out(vc0), .visible_out(vis0), .valid_out(vo0),
        .ready_in(rin), .visible_count_out(vcnt0), .culled_count_out(ccnt0)
    );

    world_to_pixel #(.PIXEL_WIDTH(1280), .PIXEL_HEIGHT(720), .WORLD_BITS(32),
                     .SCALE_LEVEL(2), .CNT_BITS(16)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .camera_x_in(cam_x), .camera_y_in(cam_y), .cam_update_in(cam_upd),
        .world_x_in(wx2), .world_y_in(wy2), .valid_in(vin), .ready_out(rdy2),
        .hcount_out(hc2), .vcount_out(vc2), .visible_out(vis2), .valid_out(vo2),
        .ready_in(rin), .visible_count_out(vcnt2), .culled_count_out(ccnt2)
    );

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pk(input logic vis, input int h, input int v);
        logic [10:0] hh;
        logic [9:0]  vv;
        hh = h[10:0];
        vv = v[9:0];
        return {vis, hh, vv};
    endfunction

    // Reference conversion with the camera at (0,0): floor-divide by 2**s, then re-centre.
    function automatic logic [W-1:0] model(input longint wx, input longint wy, input int s);
        longint px, py;
        px = (wx >>> s) + 640;
        py = (wy >>> s) + 360;
        if (px >= 0 && px < 1280 && py >= 0 && py < 720)
            return pk(1'b1, int'(px), int'(py));
        return '0;
    endfunction

    task automatic clear_q();
        src_x0.delete(); src_y0.delete(); src_x2.delete(); src_y2.delete();
        exp0_q.delete(); exp2_q.delete();
    endtask

    task automatic add_pt(input int x0, input int y0, input int x2, input int y2,
                          input logic [W-1:0] e0, input logic [W-1:0] e2);
        src_x0.push_back(x0); src_y0.push_back(y0);
        src_x2.push_back(x2); src_y2.push_back(y2);
        exp0_q.push_back(e0); exp2_q.push_back(e2);
    endtask

    // Driver and collector. It feeds n queued points, applies ready_in with the
    // given percentage, and pulses cam_update in the transfer cycle of point
    // upd_idx. It records every output transfer and any output change seen
    // during a stall.
    task automatic run_stream(input int n, input int rdy_pct, input int upd_idx,
                              input logic signed [31:0] upd_x, input logic signed [31:0] upd_y);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [W-1:0] hold0 = '0;
        logic [W-1:0] hold2 = '0;
        logic upd_taken, in_xfer, out_xfer;
        obs0_q.delete(); obs2_q.delete(); obs_cyc.delete();
        stall_viol = 0;
        @(posedge clk_in); #1;
        while (got < n && cyc < 20 * n + 100) begin
            vin = (sent < n);
            if (sent < n) begin
                wx0 = src_x0[sent]; wy0 = src_y0[sent];
                wx2 = src_x2[sent]; wy2 = src_y2[sent];
            end
            rin = ($urandom_range(99) < rdy_pct);
            @(negedge clk_in);
            in_xfer   = vin && rdy0;
            out_xfer  = vo0 && rin;
            upd_taken = in_xfer && (sent == upd_idx);
            if (upd_taken) begin
                cam_x = upd_x; cam_y = upd_y; cam_upd = 1'b1;
            end
            if (stalled && (!vo0 || !vo2 || {vis0, hc0, vc0} != hold0 || {vis2, hc2, vc2} != hold2))
                stall_viol++;
            if (out_xfer) begin
                obs0_q.push_back({vis0, hc0, vc0});
                obs_cyc.push_back(cyc);
            end
            if (vo2 && rin) obs2_q.push_back({vis2, hc2, vc2});
            stalled = vo0 && !rin;
            hold0 = {vis0, hc0, vc0};
            hold2 = {vis2, hc2, vc2};
            @(posedge clk_in); #1;
            cam_upd = 1'b0;
            if (upd_taken) begin
                upd_vcnt0 = vcnt0; upd_ccnt0 = ccnt0;
                upd_vcnt2 = vcnt2; upd_ccnt2 = ccnt2;
            end
            if (in_xfer) sent++;
            if (out_xfer) got++;
            cyc++;
        end
        vin = 1'b0;
        rin = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_in = 1'b0; vin = 1'b0; rin = 1'b1; cam_upd = 1'b0;
        cam_x = 0; cam_y = 0; wx0 = 0; wy0 = 0; wx2 = 0; wy2 = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if ({vo0, vo2, rdy0, rdy2, vis0, vis2} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=001100", {vo0, vo2, rdy0, rdy2, vis0, vis2});
        end
        checks++;
        if ({hc0, vc0, hc2, vc2} !== 42'd0) begin
            failures++;
            $display("FAIL reset_coords got=%h exp=0", {hc0, vc0, hc2, vc2});
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h exp=0", {vcnt0, ccnt0, vcnt2, ccnt2});
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({vo0, vo2} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_valid got=%b exp=00", {vo0, vo2});
        end
    endtask

    task automatic test_basic();
        clear_q();
        add_pt(0, 0, 3, -1, pk(1, 640, 360), pk(1, 640, 359));
        add_pt(-640, -360, -2560, -1440, pk(1, 0, 0), pk(1, 0, 0));
        add_pt(639, 359, 2559, 1439, pk(1, 1279, 719), pk(1, 1279, 719));
        add_pt(640, 0, 2560, 0, '0, '0);
        add_pt(0, 360, 0, -1441, '0, '0);
        add_pt(-641, 0, -2561, 0, '0, '0);
        run_stream(6, 100, -1, 0, 0);
        checks++;
        if (obs0_q.size() != 6 || obs2_q.size() != 6) begin
            failures++;
            $display("FAIL basic_count got=%0d/%0d exp=6/6", obs0_q.size(), obs2_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i]) begin
                failures++;
                $display("FAIL basic_s0[%0d] got=%h exp=%h", i, obs0_q[i], exp0_q[i]);
            end
            checks++;
            if (obs2_q[i] !== exp2_q[i]) begin
                failures++;
                $display("FAIL basic_s2[%0d] got=%h exp=%h", i, obs2_q[i], exp2_q[i]);
            end
            checks++;
            if (obs_cyc[i] !== i + 2) begin
                failures++;
                $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, obs_cyc[i], i + 2);
            end
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'd3, 16'd3, 16'd3, 16'd3}) begin
            failures++;
            $display("FAIL basic_counters got=%0d/%0d/%0d/%0d exp=3/3/3/3", vcnt0, ccnt0, vcnt2, ccnt2);
        end
    endtask

    task automatic test_cam_update();
        clear_q();
        for (int i = 0; i < 5; i++)
            add_pt(0, 0, 0, 0, (i < 2) ? pk(1, 640, 360) : pk(1, 540, 360),
                               (i < 2) ? pk(1, 640, 360) : pk(1, 615, 360));
        run_stream(5, 100, 2, 100, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i] || obs2_q[i] !== exp2_q[i]) begin
                failures++;
                $display("FAIL cam_pt[%0d] got=%h/%h exp=%h/%h", i, obs0_q[i], obs2_q[i], exp0_q[i], exp2_q[i]);
            end
        end
        checks++;
        if ({upd_vcnt0, upd_ccnt0, upd_vcnt2, upd_ccnt2} !== {16'd1, 16'd0, 16'd1, 16'd0}) begin
            failures++;
            $display("FAIL cam_upd_counters got=%0d/%0d/%0d/%0d exp=1/0/1/0", upd_vcnt0, upd_ccnt0, upd_vcnt2, upd_ccnt2);
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'd5, 16'd0, 16'd5, 16'd0}) begin
            failures++;
            $display("FAIL cam_end_counters got=%0d/%0d/%0d/%0d exp=5/0/5/0", vcnt0, ccnt0, vcnt2, ccnt2);
        end
    endtask

    task automatic test_scale2_camera();
        clear_q();
        add_pt(1000, 1000, 1400, 996, pk(1, 640, 360), pk(1, 740, 359));
        add_pt(1639, 1359, 997, 1000, pk(1, 1279, 719), pk(1, 639, 360));
        run_stream(2, 100, 0, 1000, 1000);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i]) begin
                failures++;
                $display("FAIL scale_s0[%0d] got=%h exp=%h", i, obs0_q[i], exp0_q[i]);
            end
            checks++;
            if (obs2_q[i] !== exp2_q[i]) begin
                failures++;
                $display("FAIL scale_s2[%0d] got=%h exp=%h", i, obs2_q[i], exp2_q[i]);
            end
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'd2, 16'd0, 16'd2, 16'd0}) begin
            failures++;
            $display("FAIL scale_counters got=%0d/%0d/%0d/%0d exp=2/0/2/0", vcnt0, ccnt0, vcnt2, ccnt2);
        end
    endtask

    task automatic test_backpressure();
        int x0, y0, x2, y2;
        int nvis0 = 0;
        int nvis2 = 0;
        logic [W-1:0] e0, e2;
        clear_q();
        for (int i = 0; i < 100; i++) begin
            x0 = int'($urandom_range(3000)) - 1500;
            y0 = int'($urandom_range(2000)) - 1000;
            x2 = int'($urandom_range(12000)) - 6000;
            y2 = int'($urandom_range(8000)) - 4000;
            e0 = model(x0, y0, 0);
            e2 = model(x2, y2, 2);
            nvis0 += int'(e0[W-1]);
            nvis2 += int'(e2[W-1]);
            add_pt(x0, y0, x2, y2, e0, e2);
        end
        run_stream(100, 50, 0, 0, 0);
        checks++;
        if (obs0_q.size() != 100 || obs2_q.size() != 100) begin
            failures++;
            $display("FAIL bp_count got=%0d/%0d exp=100/100", obs0_q.size(), obs2_q.size());
        end
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i] || obs2_q[i] !== exp2_q[i]) begin
                failures++;
                $display("FAIL bp_pt[%0d] got=%h/%h exp=%h/%h", i, obs0_q[i], obs2_q[i], exp0_q[i], exp2_q[i]);
            end
        end
        checks++;
        if (stall_viol !== 0) begin
            failures++;
            $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_viol);
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'(nvis0), 16'(100 - nvis0), 16'(nvis2), 16'(100 - nvis2)}) begin
            failures++;
            $display("FAIL bp_counters got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                     vcnt0, ccnt0, vcnt2, ccnt2, nvis0, 100 - nvis0, nvis2, 100 - nvis2);
        end
    endtask

    task automatic test_roundtrip_saturation();
        int h, v;
        clear_q();
        for (int i = 0; i < 70000; i++) begin
            h = int'($urandom_range(1279));
            v = int'($urandom_range(719));
            add_pt(h - 640, v - 360,
                   (h - 640) * 4 + int'($urandom_range(3)), (v - 360) * 4 + int'($urandom_range(3)),
                   pk(1, h, v), pk(1, h, v));
        end
        run_stream(70000, 100, 0, 0, 0);
        checks++;
        if (obs0_q.size() != 70000 || obs2_q.size() != 70000) begin
            failures++;
            $display("FAIL rt_count got=%0d/%0d exp=70000/70000", obs0_q.size(), obs2_q.size());
        end
        for (int i = 0; i < 10000; i++) begin
            checks++;
            if (obs0_q[i] !== exp0_q[i] || obs2_q[i] !== exp2_q[i]) begin
                failures++;
                $display("FAIL rt_pt[%0d] got=%h/%h exp=%h/%h", i, obs0_q[i], obs2_q[i], exp0_q[i], exp2_q[i]);
            end
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'hFFFF, 16'd0, 16'hFFFF, 16'd0}) begin
            failures++;
            $display("FAIL sat_counters got=%0d/%0d/%0d/%0d exp=65535/0/65535/0", vcnt0, ccnt0, vcnt2, ccnt2);
        end
    endtask

    task automatic test_reset_in_flight();
        @(posedge clk_in); #1;
        rin = 1'b1; vin = 1'b1;
        wx0 = 1; wy0 = 1; wx2 = 4; wy2 = 4;
        @(posedge clk_in); #1;
        wx0 = 2; wy0 = 2; wx2 = 8; wy2 = 8;
        @(posedge clk_in); #1;
        vin = 1'b0;
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if ({vo0, vo2, rdy0, rdy2} !== 4'b0011) begin
            failures++;
            $display("FAIL rif_flags got=%b exp=0011", {vo0, vo2, rdy0, rdy2});
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== 64'd0) begin
            failures++;
            $display("FAIL rif_counters got=%h exp=0", {vcnt0, ccnt0, vcnt2, ccnt2});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        clear_q();
        add_pt(5, 7, 20, 28, pk(1, 645, 367), pk(1, 645, 367));
        run_stream(1, 100, -1, 0, 0);
        checks++;
        if (obs0_q.size() != 1 || obs0_q[0] !== exp0_q[0] || obs2_q.size() != 1 || obs2_q[0] !== exp2_q[0]) begin
            failures++;
            $display("FAIL rif_first_out got=%h/%h n=%0d exp=%h/%h n=1",
                     obs0_q[0], obs2_q[0], obs0_q.size(), exp0_q[0], exp2_q[0]);
        end
        @(negedge clk_in);
        checks++;
        if ({vo0, vo2} !== 2'b00) begin
            failures++;
            $display("FAIL rif_no_stale got=%b exp=00", {vo0, vo2});
        end
        checks++;
        if ({vcnt0, ccnt0, vcnt2, ccnt2} !== {16'd1, 16'd0, 16'd1, 16'd0}) begin
            failures++;
            $display("FAIL rif_end_counters got=%0d/%0d/%0d/%0d exp=1/0/1/0", vcnt0, ccnt0, vcnt2, ccnt2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_cam_update();
        test_scale2_camera();
        test_backpressure();
        test_roundtrip_saturation();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
